// File: rtl/cr_prefix_attach_mem_arb_if.sv
// Bus bundle for the prefix-memory arbiter.
//   core_*  : core datapath read port (request in, yield/data/valid out)
//   reg_*   : regfile indirect-access port (held request, one-cycle ack)
//   mem_*   : single-port memory drive and read-data return
// Modports: slave = arbiter view, master = requesters + memory view.
interface cr_prefix_attach_mem_arb_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 64
) ();
  logic          core_cs;
  logic [AW-1:0] core_addr;
  logic          core_yield;
  logic [DW-1:0] core_dout;
  logic          core_vld;

  logic          reg_req;
  logic          reg_wr;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic          reg_ack;
  logic [DW-1:0] reg_rdata;

  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  core_cs, core_addr, reg_req, reg_wr, reg_addr, reg_wdata, mem_rdata,
    output core_yield, core_dout, core_vld, reg_ack, reg_rdata,
           mem_cs, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_cs, core_addr, reg_req, reg_wr, reg_addr, reg_wdata, mem_rdata,
    input  core_yield, core_dout, core_vld, reg_ack, reg_rdata,
           mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cr_prefix_attach_mem_arb.sv
// Arbitrates one single-port prefix memory between the core datapath (read-only,
// single-cycle requests, normally wins) and the regfile indirect-access path
// (held request, read/write). A starvation counter forces a register grant once
// the register path has lost STARVE_MAX consecutive cycles to the core.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : cr_prefix_attach_mem_arb_if.slave (core, reg and memory signals)
module cr_prefix_attach_mem_arb #(
  parameter int unsigned AW         = 8,
  parameter int unsigned DW         = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  cr_prefix_attach_mem_arb_if.slave    bus
);

  localparam logic [3:0] StarveMaxC = 4'(STARVE_MAX);

  typedef enum logic [1:0] {RIdle, RWait, RResp} r_state_e;

  r_state_e      state_q, state_d;
  logic [3:0]    starve_cnt_q, starve_cnt_d;
  logic          reg_ack_q;
  logic          core_vld_q;
  logic          reg_pend, reg_grant, core_grant;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] zero_data;

  assign zero_data  = '0;
  assign reg_pend   = (state_q == RWait) & bus.reg_req;
  assign reg_grant  = reg_pend & (~bus.core_cs | (starve_cnt_q == StarveMaxC));
  assign core_grant = bus.core_cs & ~reg_grant;
  assign addr_sel   = reg_grant ? bus.reg_addr : bus.core_addr;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    unique case (state_q)
      RIdle: if (bus.reg_req) state_d = RWait;
      RWait: begin
        if (reg_grant)         state_d = RResp;
        else if (!bus.reg_req) state_d = RIdle;  // requester withdrew, no access made
      end
      RResp: state_d = RIdle;  // reg_req is ignored while the ack goes out
      default: state_d = RIdle;
    endcase

    if (state_q != RWait || reg_grant) begin
      starve_cnt_d = '0;
    end else if (reg_pend && core_grant && starve_cnt_q != StarveMaxC) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RIdle;
      starve_cnt_q <= '0;
      reg_ack_q    <= 1'b0;
      core_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      reg_ack_q    <= reg_grant;
      core_vld_q   <= core_grant;
    end
  end

  assign bus.mem_cs     = core_grant | reg_grant;
  assign bus.mem_we     = reg_grant & bus.reg_wr;
  assign bus.mem_addr   = addr_sel;
  assign bus.mem_wdata  = bus.reg_wdata;

  assign bus.core_yield = bus.core_cs & reg_grant;
  assign bus.core_vld   = core_vld_q;
  assign bus.core_dout  = bus.mem_rdata;

  // Memory data arrives in the ack cycle, so it is passed through while ack is high.
  assign bus.reg_ack    = reg_ack_q;
  assign bus.reg_rdata  = reg_ack_q ? bus.mem_rdata : zero_data;

endmodule
